blink_sched: RTL and testbench
==============================

BLINK_SCHED -- requirements
Module: blink_sched

Interface
REQ-001 Parameters SHALL be:
- N, 128: block width.
- TWEAK_LEN, 256: tweak width.
- KEY_LEN, 1280: round-key bundle width, N*ROUND/2.
- WAIT_CYC, 2: settle cycles allowed for the combinational core.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept.
- req_enc  in  2  per-requester enc/dec select.
- req_P  in  2*N  per-requester plaintext; requester i uses slice [i*N +: N].
- req_T  in  2*TWEAK_LEN  per-requester tweak.
- K0  in  KEY_LEN  shared key bundle.
- core_enc  out  1  registered core input.
- core_K0  out  KEY_LEN  registered core input.
- core_P  out  N  registered core input.
- core_T  out  TWEAK_LEN  registered core input.
- core_C  in  N  core result.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_id  out  1  requester that owns the result.
- out_C  out  N  result.
- busy  out  1  FSM not in IDLE.
REQ-003 One clock, clk; reset rst SHALL be asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, WAIT, DONE.
REQ-005 In IDLE, req_ready SHALL be one-hot on the granted requester when any req_valid is set, else 0; req_ready SHALL be 0 in all other states.
REQ-006 On handshake (req_valid[g] & req_ready[g]) in IDLE:
- core_enc/core_P/core_T SHALL load requester g's fields.
- core_K0 SHALL load K0.
- out_id SHALL load g.
- counter SHALL load WAIT_CYC-1.
- FSM SHALL go to WAIT.
REQ-007 In WAIT, the counter SHALL decrement each cycle; when it is 0, out_C SHALL load core_C, out_valid SHALL be set, and FSM SHALL go to DONE.
REQ-008 Latency: handshake at edge k SHALL give out_valid high after edge k+WAIT_CYC; with WAIT_CYC=1, after edge k+1.
REQ-009 In DONE, out_valid, out_C and out_id SHALL hold until out_valid & out_ready; on that edge out_valid SHALL clear and FSM SHALL go to IDLE.
REQ-010 No new request SHALL be accepted in the DONE cycle; a back-to-back request SHALL see ready at the earliest one cycle after the out handshake.
REQ-011 core_* registers SHALL hold their values from accept until the next accept.
REQ-012 A requester deasserting req_valid without handshake SHALL be legal; no state change SHALL result.
REQ-013 busy SHALL be 1 exactly when FSM is in WAIT or DONE.
REQ-014 WAIT_CYC SHALL be at least 1; the counter width SHALL be $clog2(WAIT_CYC+1).

Reset
REQ-015 rst low SHALL, asynchronously:
- force FSM to IDLE;
- clear all registered outputs (core_*, out_C, out_id, out_valid) and the counter;
- reset the round-robin pointer to favour requester 0.
REQ-016 Reset mid-operation (WAIT or DONE) SHALL abort the operation; no result SHALL be emitted afterwards.

Configuration
REQ-017 Macro BLINK_SCHED_RR_EN, when defined, SHALL enable round-robin arbitration:
- when both requesters are valid, grant the one not granted last;
- the last-grant pointer updates on each handshake.
REQ-018 Without BLINK_SCHED_RR_EN, arbitration SHALL be fixed priority with requester 0 winning, and no pointer register SHALL exist.

Structure
REQ-019 Package blink_pkg SHALL hold N, TWEAK_LEN, ROUND, KEY_LEN and the FSM state typedef.
REQ-020 Arbitration SHALL live in sub-module blink_sched_arb: inputs valid[1:0] and handshake strobe, output one-hot grant.
REQ-021 The cipher core SHALL be instantiated outside blink_sched and connected via the core_* ports.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Single request, requester 0, enc=1, WAIT_CYC=2: out_valid rises 2 cycles after handshake; out_id=0; out_C equals model C.
- Both valid every cycle, RR_EN defined: grants alternate 0,1,0,1. Without RR_EN: all grants go to requester 0.
- out_ready held 0 for 5 cycles in DONE: out_C and out_valid stable; req_ready=0 throughout.
- rst pulsed low during WAIT: all outputs read 0 immediately; no out_valid follows; the next request completes normally.
- req_P and K0 changed after accept: out_C reflects the values captured at accept.
- WAIT_CYC=1, back-to-back requests with out_ready=1: one result every 3 cycles.

Source files
------------

// File: rtl/blink_sched_pkg.sv
// ============================================================================
// Package : blink_pkg
// Shared widths and FSM state encoding for the blink_sched scheduler.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package blink_pkg;

    localparam int N         = 128;
    localparam int TWEAK_LEN = 256;
    localparam int ROUND     = 20;
    localparam int KEY_LEN   = N * ROUND / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/blink_sched_arb.sv
// ============================================================================
// Module  : blink_sched_arb
// Two-requester arbiter producing a one-hot grant.
// Build option: define BLINK_SCHED_RR_EN for round-robin arbitration;
// otherwise fixed priority with requester 0 winning.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module blink_sched_arb
    import blink_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       hs,
    output logic [1:0] grant
);

`ifdef BLINK_SCHED_RR_EN
    // 1 when requester 1 won the most recent handshake
    logic last;

    // When both ask, serve the one that was not served last
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    // Pointer starts as if requester 1 went last so requester 0 is favoured
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (hs) begin
            last <= grant[1];
        end
    end
`else
    // Fixed priority: requester 0 always wins
    always_comb begin
        grant = 2'b00;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

    // Clock, reset and strobe have no job without the pointer
    logic unused_tie;
    assign unused_tie = ^{clk, rst, hs};
`endif

endmodule

`default_nettype wire

// File: rtl/blink_sched.sv
// ============================================================================
// Module  : blink_sched
// Two-requester front end for an external combinational cipher core:
// accepts one request, registers the core operands, waits WAIT_CYC cycles
// for the core to settle, then presents the result until it is taken.
// Build option: BLINK_SCHED_RR_EN selects round-robin arbitration.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module blink_sched
    import blink_pkg::*;
#(
    parameter int N         = blink_pkg::N,
    parameter int TWEAK_LEN = blink_pkg::TWEAK_LEN,
    parameter int KEY_LEN   = blink_pkg::KEY_LEN,
    parameter int WAIT_CYC  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_enc,
    input  logic [2*N-1:0]         req_P,
    input  logic [2*TWEAK_LEN-1:0] req_T,
    input  logic [KEY_LEN-1:0]     K0,
    output logic                   core_enc,
    output logic [KEY_LEN-1:0]     core_K0,
    output logic [N-1:0]           core_P,
    output logic [TWEAK_LEN-1:0]   core_T,
    input  logic [N-1:0]           core_C,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_id,
    output logic [N-1:0]           out_C,
    output logic                   busy
);

    localparam int            CW       = $clog2(WAIT_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic          hs;
    logic          out_hs;
    logic          sel;

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign hs        = |(req_valid & req_ready);
    assign sel       = grant[1];
    assign out_hs    = out_valid & out_ready;
    assign busy      = (state != IDLE);

    blink_sched_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .hs    (hs),
        .grant (grant)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept -> settle -> hold result until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs)          state_nxt = WAIT;
            WAIT:    if (cnt == '0)   state_nxt = DONE;
            DONE:    if (out_hs)      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Operand capture, settle counter and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_enc  <= 1'b0;
            core_K0   <= '0;
            core_P    <= '0;
            core_T    <= '0;
            out_id    <= 1'b0;
            out_C     <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (hs) begin
                core_enc <= req_enc[sel];
                core_P   <= sel ? req_P[2*N-1:N] : req_P[N-1:0];
                core_T   <= sel ? req_T[2*TWEAK_LEN-1:TWEAK_LEN] : req_T[TWEAK_LEN-1:0];
                core_K0  <= K0;
                out_id   <= sel;
                cnt      <= CNT_LOAD;
            end
            if (state == WAIT) begin
                if (cnt == '0) begin
                    out_C     <= core_C;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
            end
            if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_blink_sched.sv
// ============================================================================
// Module  : tb_blink_sched
// Self-checking bench for blink_sched with a stand-in combinational core.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_blink_sched;

    localparam int NB = blink_pkg::N;
    localparam int TL = blink_pkg::TWEAK_LEN;
    localparam int KL = blink_pkg::KEY_LEN;
    localparam int WC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main instance (WAIT_CYC = 2) ----------------
    logic [1:0]    req_valid, req_ready, req_enc;
    logic [2*NB-1:0] req_P;
    logic [2*TL-1:0] req_T;
    logic [KL-1:0] K0, core_K0;
    logic          core_enc, out_valid, out_ready, out_id, busy;
    logic [NB-1:0] core_P, core_C, out_C;
    logic [TL-1:0] core_T;

    // ---------------- second instance (WAIT_CYC = 1) ----------------
    logic [1:0]    req_valid1, req_ready1, req_enc1;
    logic [2*NB-1:0] req_P1;
    logic [2*TL-1:0] req_T1;
    logic [KL-1:0] K01, core_K01;
    logic          core_enc1, out_valid1, out_ready1, out_id1, busy1;
    logic [NB-1:0] core_P1, core_C1, out_C1;
    logic [TL-1:0] core_T1;

    // Stand-in cipher core
    function automatic logic [NB-1:0] model_c(input logic e, input logic [NB-1:0] p,
                                              input logic [TL-1:0] t, input logic [KL-1:0] k);
        logic [NB-1:0] r;
        r = p ^ t[NB-1:0] ^ t[2*NB-1:NB] ^ k[NB-1:0];
        if (e) r = {r[NB-2:0], r[NB-1]} ^ k[KL-1 -: NB];
        else   r = ~r;
        return r;
    endfunction

    assign core_C  = model_c(core_enc,  core_P,  core_T,  core_K0);
    assign core_C1 = model_c(core_enc1, core_P1, core_T1, core_K01);

    blink_sched #(.WAIT_CYC(WC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_enc(req_enc), .req_P(req_P), .req_T(req_T), .K0(K0),
        .core_enc(core_enc), .core_K0(core_K0), .core_P(core_P), .core_T(core_T),
        .core_C(core_C), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_C(out_C), .busy(busy)
    );

    blink_sched #(.WAIT_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_enc(req_enc1), .req_P(req_P1), .req_T(req_T1), .K0(K01),
        .core_enc(core_enc1), .core_K0(core_K01), .core_P(core_P1), .core_T(core_T1),
        .core_C(core_C1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_id(out_id1), .out_C(out_C1), .busy(busy1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          id;
        logic [NB-1:0] c;
    } sb_t;
    sb_t sb[$];
    int  t1q[$];
    logic [NB-1:0] exp1;

    // Scoreboard: compare each taken result against the oldest accepted request
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=out_valid required=no_result");
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_out_id", out_id, e.id);
                check("sb_out_C",  out_C,  e.c);
            end
        end
        if (rst && out_valid1 && out_ready1) begin
            t1q.push_back(cyc);
            check("b2b_out_C", out_C1, exp1);
        end
    end

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] enc;
        logic [1:0] grant;
    } vec_t;
    vec_t vec [7];

    task automatic rand_key(output logic [KL-1:0] k);
        for (int j = 0; j < KL / 32; j++) k[j*32 +: 32] = $urandom();
    endtask

    task automatic run_vec(input int i, input int hold);
        logic [NB-1:0] p0, p1, pg, ex_c;
        logic [TL-1:0] t0, t1, tg;
        logic [KL-1:0] k;
        logic          g;
        int            lat;
        sb_t           e;
        p0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        p1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        t0 = {p1 ^ 128'h5a, $urandom(), $urandom(), $urandom(), $urandom()};
        t1 = {p0, $urandom(), $urandom(), $urandom(), $urandom()};
        rand_key(k);
        req_P = {p1, p0}; req_T = {t1, t0}; req_enc = vec[i].enc; K0 = k;
        req_valid = vec[i].valid;
        #1;
        check("req_ready", req_ready, vec[i].grant);
        check("busy_idle", busy, 0);
        g    = vec[i].grant[1];
        pg   = g ? p1 : p0;
        tg   = g ? t1 : t0;
        ex_c = model_c(vec[i].enc[g], pg, tg, k);
        e.id = g; e.c = ex_c;
        sb.push_back(e);
        @(posedge clk); #1;
        // Disturb every source after accept; the result must not notice
        req_valid = 2'b00; req_P = ~req_P; req_T = ~req_T; K0 = ~K0; req_enc = ~req_enc;
        check("core_P",   core_P, pg);
        check("core_T",   core_T, tg);
        check("core_enc", core_enc, vec[i].enc[g]);
        check("core_K0",  core_K0 == k, 1);
        check("busy_wait", busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, WC);
        check("out_C_ready", out_C, ex_c);
        for (int h = 0; h < hold; h++) begin
            req_valid = 2'b11;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_C", out_C, ex_c);
            check("hold_req_ready", req_ready, 0);
        end
        req_valid = 2'b00;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_clr", out_valid, 0);
        check("busy_clr", busy, 0);
    endtask

    initial begin
        logic [KL-1:0] k;
        int            seen;
        req_valid = '0; req_enc = '0; req_P = '0; req_T = '0; K0 = '0; out_ready = 1'b0;
        req_valid1 = '0; req_enc1 = '0; req_P1 = '0; req_T1 = '0; K01 = '0; out_ready1 = 1'b0;

        //            valid  enc    grant (fixed / round-robin)
        vec[0] = {2'b01, 2'b01, 2'b01};
        vec[1] = {2'b10, 2'b00, 2'b10};
`ifdef BLINK_SCHED_RR_EN
        vec[2] = {2'b11, 2'b10, 2'b01};
        vec[3] = {2'b11, 2'b01, 2'b10};
        vec[4] = {2'b11, 2'b11, 2'b01};
        vec[5] = {2'b11, 2'b10, 2'b10};
`else
        vec[2] = {2'b11, 2'b10, 2'b01};
        vec[3] = {2'b11, 2'b01, 2'b01};
        vec[4] = {2'b11, 2'b11, 2'b01};
        vec[5] = {2'b11, 2'b10, 2'b01};
`endif
        vec[6] = {2'b11, 2'b01, 2'b01};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_core_P",    core_P, 0);
        check("rst_core_T",    core_T, 0);
        check("rst_core_enc",  core_enc, 0);
        check("rst_core_K0",   core_K0 == '0, 1);
        check("rst_out_C",     out_C, 0);
        check("rst_out_id",    out_id, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Main table, first entry held in DONE for 5 cycles
        for (int i = 0; i < 6; i++) run_vec(i, (i == 0) ? 5 : 0);

        // Reset during WAIT aborts the operation
        rand_key(k);
        K0 = k; req_P = {4{$urandom()}}; req_T = {8{$urandom()}}; req_enc = 2'b01;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("abort_busy_wait", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy",      busy, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_core_P",    core_P, 0);
        check("abort_core_T",    core_T, 0);
        check("abort_core_K0",   core_K0 == '0, 1);
        check("abort_out_C",     out_C, 0);
        check("abort_out_id",    out_id, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);

        // Pointer back at requester 0; request completes normally
        run_vec(6, 0);

        // WAIT_CYC=1, back-to-back: one result every 3 cycles
        rand_key(k);
        K01 = k; req_enc1 = 2'b01;
        req_P1 = {4{$urandom()}} ^ {NB{1'b1}} ^ {$urandom(), 224'h0};
        req_T1 = {16{$urandom()}};
        exp1 = model_c(1'b1, req_P1[NB-1:0], req_T1[TL-1:0], k);
        t1q.delete();
        out_ready1 = 1'b1;
        req_valid1 = 2'b01;
        for (int w = 0; w < 40 && t1q.size() < 4; w++) @(posedge clk);
        #1;
        req_valid1 = 2'b00;
        check("b2b_count", t1q.size() >= 4, 1);
        if (t1q.size() >= 4) begin
            for (int j = 1; j < 4; j++) check("b2b_interval", t1q[j] - t1q[j-1], 3);
        end
        repeat (4) @(posedge clk);
        #1;
        check("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
